nn_layer_sequencer: RTL and testbench

Runs a multi-layer network by reconfiguring the accelerator FSM once per layer. A host loads a small descriptor table and pulses start. The block then, for each layer:
- pulses Enable;
- drives the five configuration words onto databus with busrdwr;
- counts neuron_done pulses until the layer completes.

It sits between the host/config bus and the accelerator FSM. Each layer's output region becomes the next layer's input region.

---
 rtl/nn_accel_pkg.sv | 30 +++
 rtl/nn_layer_desc_table.sv | 57 +++++
 rtl/nn_layer_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nn_accel_pkg.sv
// Shared types and constants for the layer sequencer and its descriptor table.
package nn_accel_pkg;

  localparam int unsigned DATA_W          = 16;
  localparam int unsigned CNT_W           = 10;
  localparam int unsigned TMO_W           = 16;
  localparam int unsigned MAX_LAYERS_DEF  = 4;
  localparam int unsigned PE_SIZE_DEF     = 16;
  localparam int unsigned MAX_NEURONS_DEF = 1023;
  localparam int unsigned TIMEOUT_CYC_DEF = 65535;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_KICK, S_SEND, S_WAIT, S_NEXT, S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    F_WEIGHT = 3'd0, F_OUT = 3'd1, F_NOUT = 3'd2, F_INBASE = 3'd3, F_NIN0 = 3'd4
  } cfg_field_e;

  typedef enum logic [1:0] {
    E_NONE = 2'd0, E_COUNT = 2'd1, E_DESC = 2'd2, E_TIMEOUT = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [DATA_W-1:0] weight_addr;
    logic [DATA_W-1:0] out_addr;
    logic [DATA_W-1:0] n_out;
  } layer_desc_t;

endpackage

// File: rtl/nn_layer_desc_table.sv
// Per-layer descriptor register file plus the global input base and first-layer input size.
module nn_layer_desc_table
  import nn_accel_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = MAX_LAYERS_DEF,
  localparam int unsigned IDX_W = $clog2(MAX_LAYERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en_i,
  input  logic [IDX_W-1:0]                  wr_layer_i,
  input  logic [2:0]                        wr_field_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  input  logic [IDX_W-1:0]                  rd_idx_i,
  input  logic [IDX_W-1:0]                  rd_prev_idx_i,
  output layer_desc_t                       cur_o,
  output logic [DATA_W-1:0]                 prev_n_out_o,
  output logic [DATA_W-1:0]                 in_base_o,
  output logic [DATA_W-1:0]                 n_in0_o,
  output logic [MAX_LAYERS-1:0][DATA_W-1:0] n_out_all_o
);

  layer_desc_t [MAX_LAYERS-1:0] tbl_q;
  logic [DATA_W-1:0]            in_base_q;
  logic [DATA_W-1:0]            n_in0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q     <= '0;
      in_base_q <= '0;
      n_in0_q   <= '0;
    end else if (wr_en_i) begin
      case (cfg_field_e'(wr_field_i))
        F_WEIGHT: tbl_q[wr_layer_i].weight_addr <= wr_data_i;
        F_OUT:    tbl_q[wr_layer_i].out_addr    <= wr_data_i;
        F_NOUT:   tbl_q[wr_layer_i].n_out       <= wr_data_i;
        F_INBASE: in_base_q                     <= wr_data_i;
        F_NIN0:   n_in0_q                       <= wr_data_i;
        default: ;
      endcase
    end
  end

  assign cur_o        = tbl_q[rd_idx_i];
  assign prev_n_out_o = tbl_q[rd_prev_idx_i].n_out;
  assign in_base_o    = in_base_q;
  assign n_in0_o      = n_in0_q;

  // Flat view of every n_out so the whole run can be validated in one cycle.
  always_comb begin
    n_out_all_o = '0;
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      n_out_all_o[i] = tbl_q[i].n_out;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks the descriptor table, configuring and kicking the accelerator FSM once per layer
// and counting neuron completions before moving to the next layer.
module nn_layer_sequencer
  import nn_accel_pkg::*;
#(
  parameter int unsigned MAX_LAYERS  = MAX_LAYERS_DEF,
  parameter int unsigned PE_SIZE     = PE_SIZE_DEF,
  parameter int unsigned MAX_NEURONS = MAX_NEURONS_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_layer,
  input  logic [2:0]        cfg_field,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [2:0]        num_layers,
  input  logic              start,
  input  logic              abort,
  input  logic              neuron_done,
  output logic              Enable,
  output logic              busrdwr,
  output logic [DATA_W-1:0] databus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [1:0]        layer_idx,
  output logic [CNT_W-1:0]  neuron_cnt
);

  state_e                           state_q, state_d;
  logic [2:0]                       num_layers_q, num_layers_d;
  logic [1:0]                       layer_q, layer_d;
  logic [DATA_W-1:0]                cur_in_q, cur_in_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d, cnt_inc;
  logic [TMO_W-1:0]                 tmo_q, tmo_d, tmo_inc;
  logic [2:0]                       word_q, word_d;
  logic [1:0]                       err_code_q, err_code_d;
  logic                             enable_q, enable_d, busrdwr_q, busrdwr_d;
  logic                             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]                databus_q, databus_d;
  layer_desc_t                      cur;
  logic [DATA_W-1:0]                prev_n_out, in_base, n_in0, n_in_word;
  logic [MAX_LAYERS-1:0][DATA_W-1:0] n_out_all;
  logic                             bad_count, bad_desc, cnt_hit, tmo_hit, last_layer;
  logic                             cfg_we;

  assign cfg_we = cfg_wr && (state_q == S_IDLE) && !start;

  nn_layer_desc_table #(.MAX_LAYERS(MAX_LAYERS)) u_table (
    .clk           (clk),
    .rst_n         (rst),
    .wr_en_i       (cfg_we),
    .wr_layer_i    (cfg_layer),
    .wr_field_i    (cfg_field),
    .wr_data_i     (cfg_data),
    .rd_idx_i      (layer_q),
    .rd_prev_idx_i (layer_q - 2'd1),
    .cur_o         (cur),
    .prev_n_out_o  (prev_n_out),
    .in_base_o     (in_base),
    .n_in0_o       (n_in0),
    .n_out_all_o   (n_out_all)
  );

  // Run validation: inner layers must produce a PE-aligned input for the following layer.
  always_comb begin
    bad_count = (num_layers_q == 3'd0) || (32'(num_layers_q) > MAX_LAYERS);
    bad_desc  = (n_in0 == '0) || ((n_in0 % DATA_W'(PE_SIZE)) != '0);
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      if (i < 32'(num_layers_q)) begin
        if ((n_out_all[i] == '0) || (n_out_all[i] > DATA_W'(MAX_NEURONS))) bad_desc = 1'b1;
      end
      if ((i + 1) < 32'(num_layers_q)) begin
        if ((n_out_all[i] % DATA_W'(PE_SIZE)) != '0) bad_desc = 1'b1;
      end
    end
  end

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign tmo_inc    = tmo_q + TMO_W'(1);
  assign cnt_hit    = neuron_done && (DATA_W'(cnt_inc) == cur.n_out);
  assign tmo_hit    = !neuron_done && (tmo_inc == TMO_W'(TIMEOUT_CYC));
  assign last_layer = (({1'b0, layer_q} + 3'd1) == num_layers_q);
  assign n_in_word  = (layer_q == 2'd0) ? n_in0 : prev_n_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = (bad_count || bad_desc) ? S_IDLE : S_KICK;
      S_KICK:   state_d = S_SEND;
      S_SEND:   if (word_q == 3'd4) state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_hit)      state_d = S_NEXT;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_NEXT:   state_d = last_layer ? S_FINISH : S_KICK;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Datapath updates and registered outputs derived from the upcoming state.
  always_comb begin
    num_layers_d = num_layers_q;
    layer_d      = layer_q;
    cur_in_d     = cur_in_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    word_d       = word_q;
    err_code_d   = err_code_q;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        num_layers_d = num_layers;
        err_code_d   = E_NONE;
      end
      S_CHECK: begin
        if (bad_count) begin
          err_d      = 1'b1;
          err_code_d = E_COUNT;
        end else if (bad_desc) begin
          err_d      = 1'b1;
          err_code_d = E_DESC;
        end else begin
          layer_d  = 2'd0;
          cur_in_d = in_base;
        end
      end
      S_SEND: begin
        word_d = word_q + 3'd1;
        if (word_q == 3'd4) begin
          word_d = 3'd0;
          cnt_d  = '0;
          tmo_d  = '0;
        end
      end
      S_WAIT: begin
        if (neuron_done) begin
          cnt_d = cnt_inc;
          tmo_d = '0;
        end else if (!tmo_hit) begin
          tmo_d = tmo_inc;
        end
        if (tmo_hit) begin
          err_d      = 1'b1;
          err_code_d = E_TIMEOUT;
        end
      end
      S_NEXT: begin
        cur_in_d = cur.out_addr;
        if (!last_layer) layer_d = layer_q + 2'd1;
      end
      default: ;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      err_d      = 1'b0;
      err_code_d = err_code_q;
      word_d     = 3'd0;
    end

    enable_d  = (state_d == S_KICK);
    busrdwr_d = (state_d == S_SEND);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FINISH);
    databus_d = '0;
    if (state_d == S_SEND) begin
      case (word_d)
        3'd0:    databus_d = cur_in_q;
        3'd1:    databus_d = cur.weight_addr;
        3'd2:    databus_d = cur.out_addr;
        3'd3:    databus_d = n_in_word;
        default: databus_d = cur.n_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_layers_q <= '0;
      layer_q      <= '0;
      cur_in_q     <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      word_q       <= '0;
      err_code_q   <= '0;
      enable_q     <= 1'b0;
      busrdwr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      databus_q    <= '0;
    end else begin
      num_layers_q <= num_layers_d;
      layer_q      <= layer_d;
      cur_in_q     <= cur_in_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      word_q       <= word_d;
      err_code_q   <= err_code_d;
      enable_q     <= enable_d;
      busrdwr_q    <= busrdwr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      databus_q    <= databus_d;
    end
  end

  assign Enable     = enable_q;
  assign busrdwr    = busrdwr_q;
  assign databus    = databus_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign layer_idx  = layer_q;
  assign neuron_cnt = cnt_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_wr, start, abort, neuron_done;
  logic [1:0]  cfg_layer;
  logic [2:0]  cfg_field, num_layers;
  logic [15:0] cfg_data;
  logic        Enable, busrdwr, busy, done, err;
  logic [15:0] databus;
  logic [1:0]  err_code, layer_idx;
  logic [9:0]  neuron_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer), .cfg_field(cfg_field),
    .cfg_data(cfg_data), .num_layers(num_layers), .start(start), .abort(abort),
    .neuron_done(neuron_done), .Enable(Enable), .busrdwr(busrdwr), .databus(databus),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .layer_idx(layer_idx),
    .neuron_cnt(neuron_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] l, input logic [2:0] f, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_layer = l; cfg_field = f; cfg_data = d;
    step();
    cfg_wr = 1'b0;
  endtask

  // Returns on the cycle the sequencer sits in its validation state.
  task automatic go(input logic [2:0] n);
    num_layers = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_check(input string t, input logic [15:0] w0, w1, w2, w3, w4);
    logic [15:0] w [5];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("%s_word%0d", t, i), {busrdwr, databus}, {1'b1, w[i]});
    end
    step();
    chk({t, "_bus_idle"}, {busrdwr, databus, neuron_cnt}, '0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      neuron_done = 1'b1;
      step();
    end
    neuron_done = 1'b0;
  endtask

  task automatic run1(input string t);
    go(3'd1);
    chk({t, "_check"}, {busy, Enable}, 2'b10);
    step();
    chk({t, "_kick"}, {Enable, busrdwr, layer_idx}, 4'b1000);
    send_check(t, 16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd3);
    pulses(3);
    chk({t, "_cnt"}, {done, neuron_cnt}, {1'b0, 10'd3});
    step();
    chk({t, "_done"}, {done, err, busy}, 3'b101);
    step();
    chk({t, "_after"}, {done, busy}, 2'b00);
  endtask

  initial begin
    cfg_wr = 1'b0; start = 1'b0; abort = 1'b0; neuron_done = 1'b0;
    cfg_layer = '0; cfg_field = '0; cfg_data = '0; num_layers = '0;
    repeat (2) step();
    chk("reset_outputs", {Enable, busrdwr, databus, busy, done, err, err_code, layer_idx, neuron_cnt}, '0);
    rst = 1'b1;
    step();

    cfg(2'd0, 3'd3, 16'h0100);
    cfg(2'd0, 3'd4, 16'd32);
    cfg(2'd0, 3'd0, 16'h2000);
    cfg(2'd0, 3'd1, 16'h0400);
    cfg(2'd0, 3'd2, 16'd3);
    run1("one_layer");

    // Two layers: layer 0 output region feeds layer 1.
    cfg(2'd0, 3'd2, 16'd16);
    cfg(2'd1, 3'd0, 16'h3000);
    cfg(2'd1, 3'd1, 16'h0800);
    cfg(2'd1, 3'd2, 16'd2);
    go(3'd2);
    step();
    chk("two_kick0", {Enable, layer_idx}, 3'b100);
    send_check("two_l0", 16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd16);
    pulses(16);
    chk("two_cnt0", {done, neuron_cnt}, {1'b0, 10'd16});
    step();
    chk("two_kick1", {Enable, done, layer_idx}, 4'b1001);
    send_check("two_l1", 16'h0400, 16'h3000, 16'h0800, 16'd16, 16'd2);
    pulses(2);
    step();
    chk("two_done", {done, layer_idx}, 3'b101);
    step();
    chk("two_idle", {busy, done}, 2'b00);

    go(3'd0);
    chk("rej0_check", err, 1'b0);
    step();
    chk("rej0_err", {err, err_code, Enable, busy}, 5'b10100);
    step();
    chk("rej0_hold", {err, err_code}, 3'b001);

    cfg(2'd0, 3'd4, 16'd20);
    go(3'd1);
    step();
    chk("rej_nin0", {err, err_code, Enable}, 4'b1100);

    cfg(2'd0, 3'd4, 16'd32);
    cfg(2'd0, 3'd2, 16'd10);
    go(3'd2);
    step();
    chk("rej_nout_align", {err, err_code, Enable}, 4'b1100);
    cfg(2'd0, 3'd2, 16'd3);

    go(3'd1);
    step();
    send_check("tmo", 16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd3);
    repeat (99) step();
    chk("tmo_pending", {err, busy}, 2'b01);
    step();
    chk("tmo_err", {err, err_code, busy}, 4'b1110);

    go(3'd1);
    repeat (4) step();
    chk("abort_word2", {busrdwr, databus}, {1'b1, 16'h0400});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", {busrdwr, databus, busy, done, err, Enable, err_code}, '0);
    step();
    chk("abort_quiet", {done, err}, 2'b00);
    run1("post_abort");

    // Writes while a run is in flight must not disturb the table.
    go(3'd1);
    step();
    send_check("guard", 16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd3);
    cfg(2'd0, 3'd2, 16'd7);
    cfg(2'd0, 3'd0, 16'h5555);
    pulses(3);
    step();
    chk("guard_done", {done, neuron_cnt}, {1'b1, 10'd3});
    step();
    run1("guard_rerun");

    go(3'd1);
    step();
    send_check("rstrun", 16'h0100, 16'h2000, 16'h0400, 16'd32, 16'd3);
    pulses(1);
    chk("rst_cnt1", {busy, neuron_cnt}, {1'b1, 10'd1});
    #2 rst = 1'b0;
    #1 chk("rst_async", {Enable, busrdwr, databus, busy, done, err, err_code, layer_idx, neuron_cnt}, '0);
    step();
    rst = 1'b1;
    step();
    go(3'd1);
    step();
    chk("rst_table_cleared", {err, err_code, Enable}, 4'b1100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
